// File: rtl/enemy_pkg.sv
// Shared types and constants for the opponent sequencing controller.
package enemy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MOVE    = 3'd1,
        ST_WINDUP  = 3'd2,
        ST_PUNCH   = 3'd3,
        ST_STUNNED = 3'd4,
        ST_KO      = 3'd5
    } enemy_state_t;

    localparam logic [1:0] X_LEFT   = 2'b00;
    localparam logic [1:0] X_CENTER = 2'b01;
    localparam logic [1:0] X_RIGHT  = 2'b10;

    localparam int HEALTH_W = 4;

    // Next lane of the 01->10->01->00 ping-pong walk.
    function automatic logic [1:0] lane_step(input logic [1:0] x, input logic going_right);
        if (x == X_CENTER) return going_right ? X_RIGHT : X_LEFT;
        return X_CENTER;
    endfunction

endpackage

// File: rtl/enemy_tick_counter.sv
// Loadable down-counter advanced by the datapath move tick; done marks the final tick.
module enemy_tick_counter
    import enemy_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         move,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (move && count != '0)
            count <= count - W'(1);
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/enemy_controller.sv
// Opponent move / wind-up / punch / stunned sequencer with health tracking.
// Optional build macro ENEMY_CTRL_RAGE_EN enables the low-health rage mode.
module enemy_controller
    import enemy_pkg::*;
#(
    parameter int HEALTH_INIT  = 8,
    parameter int PUNCH_EVERY  = 4,
    parameter int WINDUP_TICKS = 2,
    parameter int STUN_TICKS   = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                move,
    input  logic                player_punch,
    input  logic                player_dodge,
    output logic [1:0]          x_pos,
    output logic                speed,
    output logic                attack,
    output logic                strike,
    output logic [HEALTH_W-1:0] health,
    output logic                ko
);

    localparam int MC_W  = (PUNCH_EVERY > 1) ? $clog2(PUNCH_EVERY) : 1;
    localparam int T_MAX = (WINDUP_TICKS > STUN_TICKS) ? WINDUP_TICKS : STUN_TICKS;
    localparam int TC_W  = $clog2(T_MAX + 1);
    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(HEALTH_INIT);

    enemy_state_t        state, state_d;
    logic [1:0]          x_d;
    logic                going_right, going_right_d;
    logic [MC_W-1:0]     move_count, move_count_d;
    logic [HEALTH_W-1:0] health_d;
    logic                strike_d;
    logic                tick_load;
    logic [TC_W-1:0]     tick_load_value;
    logic                tick_done;
    logic [TC_W-1:0]     windup_len;

    enemy_tick_counter #(.W(TC_W)) u_tick_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tick_load),
        .load_value (tick_load_value),
        .move       (move),
        .done       (tick_done)
    );

`ifdef ENEMY_CTRL_RAGE_EN
    localparam int RAGE_WINDUP = (WINDUP_TICKS / 2 > 1) ? WINDUP_TICKS / 2 : 1;
    localparam logic [HEALTH_W-1:0] HEALTH_HALF = HEALTH_W'(HEALTH_INIT / 2);

    logic speed_d;

    assign windup_len = (health <= HEALTH_HALF) ? TC_W'(RAGE_WINDUP) : TC_W'(WINDUP_TICKS);
    assign speed_d    = (health_d <= HEALTH_HALF) && (state_d != ST_IDLE) && (state_d != ST_KO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) speed <= 1'b0;
        else          speed <= speed_d;
    end
`else
    assign windup_len = TC_W'(WINDUP_TICKS);
    assign speed      = 1'b0;
`endif

    always_comb begin
        state_d         = state;
        x_d             = x_pos;
        going_right_d   = going_right;
        move_count_d    = move_count;
        health_d        = health;
        strike_d        = 1'b0;
        tick_load       = 1'b0;
        tick_load_value = '0;

        unique case (state)
            ST_IDLE, ST_KO: begin
                if (start) begin
                    state_d       = ST_MOVE;
                    health_d      = HEALTH_FULL;
                    move_count_d  = '0;
                    x_d           = X_CENTER;
                    going_right_d = 1'b1;
                    tick_load     = 1'b1;
                end
            end
            ST_MOVE: begin
                if (move) begin
                    x_d = lane_step(x_pos, going_right);
                    if (x_d == X_RIGHT) going_right_d = 1'b0;
                    if (x_d == X_LEFT)  going_right_d = 1'b1;
                    if (move_count == MC_W'(PUNCH_EVERY - 1)) begin
                        move_count_d    = '0;
                        state_d         = ST_WINDUP;
                        tick_load       = 1'b1;
                        tick_load_value = windup_len;
                    end else begin
                        move_count_d = move_count + MC_W'(1);
                    end
                end
            end
            ST_WINDUP: begin
                if (move && tick_done) state_d = ST_PUNCH;
            end
            ST_PUNCH: begin
                if (player_dodge) begin
                    state_d         = ST_STUNNED;
                    tick_load       = 1'b1;
                    tick_load_value = TC_W'(STUN_TICKS);
                end else begin
                    strike_d = 1'b1;
                    state_d  = ST_MOVE;
                end
            end
            ST_STUNNED: begin
                // A hit landing with the last stun tick still counts and may knock out.
                if (player_punch && health != '0) health_d = health - HEALTH_W'(1);
                if (player_punch && health <= HEALTH_W'(1))
                    state_d = ST_KO;
                else if (move && tick_done)
                    state_d = ST_MOVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            x_pos       <= X_CENTER;
            going_right <= 1'b1;
            move_count  <= '0;
            health      <= HEALTH_FULL;
            strike      <= 1'b0;
            attack      <= 1'b0;
            ko          <= 1'b0;
        end else begin
            state       <= state_d;
            x_pos       <= x_d;
            going_right <= going_right_d;
            move_count  <= move_count_d;
            health      <= health_d;
            strike      <= strike_d;
            attack      <= (state_d == ST_WINDUP);
            ko          <= (state_d == ST_KO);
        end
    end

endmodule

// File: tb/tb_enemy_controller.sv
// Directed and randomized bench for enemy_controller against a behavioural bout model.
module tb_enemy_controller;

    localparam int HEALTH_INIT  = 8;
    localparam int PUNCH_EVERY  = 4;
    localparam int WINDUP_TICKS = 2;
    localparam int STUN_TICKS   = 3;
`ifdef ENEMY_CTRL_RAGE_EN
    localparam bit RAGE = 1'b1;
`else
    localparam bit RAGE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n, start, move, player_punch, player_dodge;
    logic [1:0] x_pos;
    logic       speed, attack, strike, ko;
    logic [3:0] health;

    enemy_controller #(
        .HEALTH_INIT(HEALTH_INIT), .PUNCH_EVERY(PUNCH_EVERY),
        .WINDUP_TICKS(WINDUP_TICKS), .STUN_TICKS(STUN_TICKS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .move(move),
        .player_punch(player_punch), .player_dodge(player_dodge),
        .x_pos(x_pos), .speed(speed), .attack(attack), .strike(strike),
        .health(health), .ko(ko)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Bout model: phase of the bout, position along the lane walk, and plain counters.
    typedef enum int {M_IDLE, M_MOVE, M_WINDUP, M_PUNCH, M_STUNNED, M_KO} mode_t;
    mode_t m_mode;
    int    m_step, m_moves, m_timer, m_health;
    bit    m_strike;
    int    lane_seq[4] = '{1, 2, 1, 0};

    function automatic void model_reset();
        m_mode = M_IDLE; m_step = 0; m_moves = 0; m_timer = 0;
        m_health = HEALTH_INIT; m_strike = 1'b0;
    endfunction

    function automatic int model_windup_len();
        if (RAGE && m_health <= HEALTH_INIT / 2)
            return (WINDUP_TICKS / 2 > 1) ? WINDUP_TICKS / 2 : 1;
        return WINDUP_TICKS;
    endfunction

    function automatic void model_edge(bit st, bit mv, bit pp, bit dg);
        m_strike = 1'b0;
        case (m_mode)
            M_IDLE, M_KO: if (st) begin
                m_mode = M_MOVE; m_health = HEALTH_INIT; m_step = 0; m_moves = 0;
            end
            M_MOVE: if (mv) begin
                m_step = (m_step + 1) % 4;
                m_moves++;
                if (m_moves == PUNCH_EVERY) begin
                    m_moves = 0; m_mode = M_WINDUP; m_timer = model_windup_len();
                end
            end
            M_WINDUP: if (mv) begin
                m_timer--;
                if (m_timer == 0) m_mode = M_PUNCH;
            end
            M_PUNCH: if (dg) begin
                m_mode = M_STUNNED; m_timer = STUN_TICKS;
            end else begin
                m_strike = 1'b1; m_mode = M_MOVE;
            end
            M_STUNNED: begin
                if (pp && m_health > 0) m_health--;
                if (mv) m_timer--;
                if (pp && m_health == 0) m_mode = M_KO;
                else if (m_timer == 0)   m_mode = M_MOVE;
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_outputs();
        bit exp_speed;
        exp_speed = RAGE && (m_health <= HEALTH_INIT / 2) && m_mode != M_IDLE && m_mode != M_KO;
        chk("x_pos",  8'(x_pos),  8'(lane_seq[m_step]));
        chk("attack", 8'(attack), 8'(m_mode == M_WINDUP));
        chk("strike", 8'(strike), 8'(m_strike));
        chk("health", 8'(health), 8'(m_health));
        chk("ko",     8'(ko),     8'(m_mode == M_KO));
        chk("speed",  8'(speed),  8'(exp_speed));
    endtask

    task automatic step(input bit st, input bit mv, input bit pp, input bit dg);
        start = st; move = mv; player_punch = pp; player_dodge = dg;
        @(posedge clock);
        model_edge(st, mv, pp, dg);
        #1;
        start = 1'b0; move = 1'b0; player_punch = 1'b0;
        chk_outputs();
    endtask

    task automatic run_to_stun(output int wl);
        for (int i = 0; i < PUNCH_EVERY; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        wl = 0;
        while (attack === 1'b1 && wl < 20) begin
            step(0, 1, 0, 0);
            wl++;
        end
        step(0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wl;
        int x_ko;
        logic [1:0] exp_x [4] = '{2'b10, 2'b01, 2'b00, 2'b01};

        reset_n = 1'b0; start = 1'b0; move = 1'b0; player_punch = 1'b0; player_dodge = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        chk("rst_x_pos",  8'(x_pos),  8'd1);
        chk("rst_attack", 8'(attack), 8'd0);
        chk("rst_strike", 8'(strike), 8'd0);
        chk("rst_health", 8'(health), 8'd8);
        chk("rst_ko",     8'(ko),     8'd0);
        chk("rst_speed",  8'(speed),  8'd0);

        // Start a bout and walk four ticks into the wind-up.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            chk("walk_x", 8'(x_pos), 8'(exp_x[i]));
            step(0, 0, 0, 0);
        end
        chk("windup_attack", 8'(attack), 8'd1);
        step(0, 0, 1, 0);
        chk("windup_punch_blocked", 8'(health), 8'd8);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("punch_attack_low", 8'(attack), 8'd0);
        step(0, 0, 0, 0);
        chk("strike_pulse", 8'(strike), 8'd1);
        step(0, 0, 0, 0);
        chk("strike_single", 8'(strike), 8'd0);
        chk("strike_health", 8'(health), 8'd8);

        // Dodged punch, three hits while stunned, then a blocked hit in MOVE.
        run_to_stun(wl);
        chk("dodge_no_strike", 8'(strike), 8'd0);
        repeat (3) step(0, 0, 1, 0);
        chk("stun_health5", 8'(health), 8'd5);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("move_punch_blocked", 8'(health), 8'd5);

        run_to_stun(wl);
        chk("windup_len_full", 8'(wl), 8'd2);
        step(0, 0, 1, 0);
        chk("health4", 8'(health), 8'd4);
        chk("rage_speed", 8'(speed), 8'(RAGE));
        repeat (3) step(0, 1, 0, 0);

        run_to_stun(wl);
        chk("windup_len_rage", 8'(wl), RAGE ? 8'd1 : 8'd2);
        repeat (3) step(0, 0, 1, 0);
        chk("health1", 8'(health), 8'd1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("ko_health", 8'(health), 8'd0);
        chk("ko_flag", 8'(ko), 8'd1);
        x_ko = lane_seq[m_step];
        repeat (3) step(0, 1, 1, 0);
        chk("ko_x_frozen", 8'(x_pos), 8'(x_ko));
        step(1, 0, 0, 0);
        chk("restart_health", 8'(health), 8'd8);
        chk("restart_ko", 8'(ko), 8'd0);
        chk("restart_x", 8'(x_pos), 8'd1);

        // Asynchronous reset in the middle of a wind-up.
        for (int i = 0; i < PUNCH_EVERY; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        reset_n = 1'b0;
        #2;
        model_reset();
        chk_outputs();
        @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (3) step(0, 1, 1, 1);
        chk("idle_hold_attack", 8'(attack), 8'd0);
        chk("idle_hold_x", 8'(x_pos), 8'd1);

        // Randomized bouts.
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/enemy_controller.md
# enemy_controller

Sequencing controller for the opponent datapath in the punch-out game. Drives the datapath's `x_pos`, `speed` and `attack` controls and consumes its `move` tick. Runs the opponent's move / wind-up / punch / stunned cycle, tracks opponent health, and produces the strike pulse that damages the player. Sits between the top-level game FSM (start, player inputs) and the enemy datapath.

## Interface
- `HEALTH_INIT`, default 8: opponent health loaded at reset and on restart; 1..15.
- `PUNCH_EVERY`, default 4: MOVE-state ticks per punch cycle; ≥1.
- `WINDUP_TICKS`, default 2: ticks spent telegraphing before a punch; ≥1.
- `STUN_TICKS`, default 3: ticks the opponent stays vulnerable after a dodged punch; ≥1.
- `clock`, in, 1: system clock.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; begins or restarts a bout. Honoured only in IDLE or KO.
- `move`, in, 1: one-cycle tick from the datapath. All movement and timing advances on it.
- `player_punch`, in, 1: one-cycle pulse, player throws a punch.
- `player_dodge`, in, 1: level, player is dodging.
- `x_pos`, out, 2: lane to the datapath. 00 = left, 01 = centre, 10 = right. 11 is never driven.
- `speed`, out, 1: datapath rate select.
- `attack`, out, 1: high while in WINDUP.
- `strike`, out, 1: one-cycle pulse, the player was hit.
- `health`, out, 4: opponent health.
- `ko`, out, 1: high while in KO.

## Operation
- States: IDLE, MOVE, WINDUP, PUNCH, STUNNED, KO. Encoding is 3-bit, defined in the package.
- IDLE: `start` moves to MOVE and loads `health` = HEALTH_INIT. Move count and tick counter are cleared, `x_pos` is set to 01 and direction is set to right.
- MOVE, on each `move` tick:
  - `x_pos` ping-pongs 01→10→01→00→01…; direction reverses at 00 and at 10.
  - Move count increments.
  - On the PUNCH_EVERY-th tick, `x_pos` still steps, the count clears, and the state goes to WINDUP.
  - `player_punch` is blocked in MOVE: no health change.
- WINDUP: `x_pos` is frozen and `attack` = 1. After WINDUP_TICKS ticks the state goes to PUNCH. `player_punch` is blocked.
- PUNCH: lasts exactly one clock, and `player_dodge` is sampled at its edge.
  - Dodge low: `strike` pulses and the state returns to MOVE.
  - Dodge high: no strike, and the state goes to STUNNED.
- STUNNED: each `player_punch` pulse decrements `health`, saturating at 0. After STUN_TICKS ticks the state returns to MOVE.
- KO: entered on the edge where `health` becomes 0. `ko` = 1, and `x_pos` and `health` are frozen. Ticks and punches are ignored. `start` restarts exactly as from IDLE.
- Simultaneous events:
  - `player_punch` together with the final STUNNED tick: the hit is counted. If health reaches 0 the state goes to KO; otherwise it goes to MOVE.
  - `start` outside IDLE or KO is ignored.
  - `move` in PUNCH is ignored.
- Without the optional feature, `speed` is a constant 0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `x_pos` = 01, `speed` = 0, `attack` = 0, `strike` = 0, `health` = HEALTH_INIT, `ko` = 0.
- Reset is asynchronous. Asserting it mid-bout forces all of the above immediately, regardless of `move`.
- A state change takes effect on the edge sampling the tick or pulse. New outputs are visible the following cycle.
- `strike` is high for exactly the one cycle after the PUNCH edge. It is never high for two consecutive cycles.
- `attack` is high for every cycle in WINDUP, and low in PUNCH.

## Configuration
- `ENEMY_CTRL_RAGE_EN` defined:
  - `speed` = 1 whenever `health` ≤ HEALTH_INIT/2 (integer division) and the state is not IDLE or KO.
  - In that condition the WINDUP length is max(1, WINDUP_TICKS/2).
  - `speed` updates on the edge where `health` changes.
- Undefined: `speed` is tied to 0, the WINDUP length is always WINDUP_TICKS, and the rage comparison logic is absent.

## Structure
- Package `enemy_pkg` holds:
  - the state typedef and encoding;
  - lane constants X_LEFT = 2'b00, X_CENTER = 2'b01, X_RIGHT = 2'b10;
  - the health width constant (4).
- Sub-module `enemy_tick_counter`:
  - a loadable down-counter advanced by `move`, with a `done` flag;
  - shared by WINDUP and STUNNED timing;
  - MOVE uses a separate move count.

## Test plan
All scenarios use default parameters.
- Reset, `start`, then 4 `move` ticks: `x_pos` = 10, 01, 00, 01. State is WINDUP after tick 4, `attack` = 1.
- In WINDUP, 2 ticks with `player_dodge` = 0: state passes through PUNCH, `strike` is high for exactly 1 cycle, state returns to MOVE, `health` stays 8.
- PUNCH with `player_dodge` = 1: no strike, state STUNNED. Three `player_punch` pulses give `health` = 5. After 3 ticks the state is MOVE. A `player_punch` pulse in MOVE leaves `health` = 5.
- `health` = 1 in STUNNED, with `player_punch` on the same cycle as the last tick: `health` = 0, `ko` = 1, and later ticks do not change `x_pos`. Then `start`: `health` = 8, `ko` = 0, MOVE, `x_pos` = 01.
- `reset_n` low mid-WINDUP, with no clock edge: outputs immediately take their reset values. After release, the controller stays in IDLE until `start`.
- With `ENEMY_CTRL_RAGE_EN` defined, reduce `health` to 4: `speed` = 1, and the next WINDUP lasts 1 tick. Without the macro, `speed` stays 0 throughout.
